// File: rtl/ita_weight_bank_scheduler.sv
// Ping-pong scheduler for the two-entry ITA weight buffer: fills one bank chunk by
// chunk while the datapath re-reads the other, then swaps. Data bypasses this block.
module ita_weight_bank_scheduler #(
  parameter int unsigned N_WRITE_EN = 8,
  parameter int unsigned REUSE_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inp_weight_valid_i,
  output logic                  inp_weight_ready_o,
  input  logic [REUSE_W-1:0]    reuse_count_i,
  input  logic                  flush_i,
  output logic                  weight_valid_o,
  input  logic                  weight_ready_i,
  output logic                  read_en_o,
  output logic                  read_addr_o,
  output logic                  write_en_o,
  output logic                  write_addr_o,
  output logic [N_WRITE_EN-1:0] write_select_o,
  output logic                  busy_o
);

  localparam int unsigned CW = (N_WRITE_EN > 1) ? $clog2(N_WRITE_EN) : 1;

  logic [1:0]               full_r, full_s;
  logic [1:0][REUSE_W-1:0]  reuse_left_r, reuse_left_s;
  logic                     wb_r, wb_s;
  logic                     rb_r, rb_s;
  logic [CW-1:0]            c_r, c_s;

  logic                     in_ready_s;
  logic                     w_valid_s;
  logic                     wr_fire_s;
  logic                     rd_fire_s;
  logic                     last_chunk_s;
  logic                     release_s;
  logic [REUSE_W-1:0]       reuse_load_s;

  // Handshake decode from registered state and current inputs.
  always_comb begin
    in_ready_s   = !rst_i && !flush_i && !full_r[wb_r];
    w_valid_s    = !rst_i && !flush_i && full_r[rb_r];
    wr_fire_s    = inp_weight_valid_i && in_ready_s;
    rd_fire_s    = w_valid_s && weight_ready_i;
    last_chunk_s = (c_r == CW'(N_WRITE_EN - 1));
    // A full bank always holds a count >= 1; <= keeps a corrupted 0 from locking the bank.
    release_s    = rd_fire_s && (reuse_left_r[rb_r] <= REUSE_W'(1'b1));
    if (reuse_count_i == {REUSE_W{1'b0}}) begin
      reuse_load_s = REUSE_W'(1'b1);
    end else begin
      reuse_load_s = reuse_count_i;
    end
  end

  // Next-state: fill completion and release touch different banks, so both apply.
  always_comb begin
    full_s       = full_r;
    reuse_left_s = reuse_left_r;
    wb_s         = wb_r;
    rb_s         = rb_r;
    c_s          = c_r;
    if (wr_fire_s) begin
      if (last_chunk_s) begin
        full_s[wb_r]       = 1'b1;
        reuse_left_s[wb_r] = reuse_load_s;
        wb_s               = !wb_r;
        c_s                = {CW{1'b0}};
      end else begin
        c_s = c_r + CW'(1'b1);
      end
    end else begin
      c_s = c_r;
    end
    if (rd_fire_s) begin
      reuse_left_s[rb_r] = reuse_left_r[rb_r] - REUSE_W'(1'b1);
      if (release_s) begin
        full_s[rb_r] = 1'b0;
        rb_s         = !rb_r;
      end else begin
        rb_s = rb_r;
      end
    end else begin
      rb_s = rb_r;
    end
  end

  // Bank state register; reset and flush both discard everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      full_r       <= 2'b00;
      reuse_left_r <= '0;
      wb_r         <= 1'b0;
      rb_r         <= 1'b0;
      c_r          <= {CW{1'b0}};
    end else begin
      full_r       <= full_s;
      reuse_left_r <= reuse_left_s;
      wb_r         <= wb_s;
      rb_r         <= rb_s;
      c_r          <= c_s;
    end
  end

  // Output drive; reset holds every output low, addresses otherwise track the pointers.
  always_comb begin
    inp_weight_ready_o = in_ready_s;
    weight_valid_o     = w_valid_s;
    write_en_o         = wr_fire_s;
    read_en_o          = rd_fire_s;
    if (rst_i) begin
      write_addr_o = 1'b0;
      read_addr_o  = 1'b0;
      busy_o       = 1'b0;
    end else begin
      write_addr_o = wb_r;
      read_addr_o  = rb_r;
      busy_o       = (|full_r) || (c_r != {CW{1'b0}});
    end
    if (wr_fire_s) begin
      write_select_o = N_WRITE_EN'(1'b1) << c_r;
    end else begin
      write_select_o = {N_WRITE_EN{1'b0}};
    end
  end

endmodule

// File: tb/tb_ita_weight_bank_scheduler.sv
// Table-driven bench for ita_weight_bank_scheduler (N_WRITE_EN=4): per-cycle stimulus
// rows with hand-derived expected outputs, routed through a scoreboard queue.
module tb_ita_weight_bank_scheduler;

  localparam int unsigned NW = 4;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] reuse;
  logic          flush;
  logic          w_valid;
  logic          w_ready;
  logic          rd_en;
  logic          rd_addr;
  logic          wr_en;
  logic          wr_addr;
  logic [NW-1:0] wsel;
  logic          busy;

  always #5 clk = ~clk;

  ita_weight_bank_scheduler #(.N_WRITE_EN(NW), .REUSE_W(RW)) dut (
    .clk_i(clk), .rst_i(rst),
    .inp_weight_valid_i(in_valid), .inp_weight_ready_o(in_ready),
    .reuse_count_i(reuse), .flush_i(flush),
    .weight_valid_o(w_valid), .weight_ready_i(w_ready),
    .read_en_o(rd_en), .read_addr_o(rd_addr),
    .write_en_o(wr_en), .write_addr_o(wr_addr),
    .write_select_o(wsel), .busy_o(busy)
  );

  // expected vector: {in_ready, w_valid, rd_en, rd_addr, wr_en, wr_addr, wsel[3:0], busy}
  typedef struct {
    logic          rst;
    logic          flush;
    logic          valid;
    logic          wready;
    logic [RW-1:0] reuse;
    logic [10:0]   exp;
    string         tag;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [10:0] e(input logic ir, input logic wv, input logic re,
                                    input logic ra, input logic we, input logic wa,
                                    input logic [3:0] ws, input logic bz);
    return {ir, wv, re, ra, we, wa, ws, bz};
  endfunction

  task automatic add(input logic r, input logic f, input logic v, input logic wr,
                     input int unsigned ru, input logic [10:0] x, input string tag);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.wready = wr; t.reuse = RW'(ru); t.exp = x; t.tag = tag;
    vecs.push_back(t);
  endtask

  // Fresh fill of both banks from an idle scheduler with the read side stalled.
  task automatic add_fill(input int unsigned n, input int unsigned ru, input string tag);
    logic [3:0] one;
    for (int i = 0; i < int'(n); i++) begin
      one = 4'b0001 << (i % 4);
      add(1'b0, 1'b0, 1'b1, 1'b0, ru,
          e(1'b1, i >= 4, 1'b0, 1'b0, 1'b1, i >= 4, one, i != 0), tag);
    end
  endtask

  initial begin
    logic [10:0] got;
    logic [10:0] want;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; w_ready = 1'b0; reuse = '0;

    add(1'b1, 1'b0, 1'b1, 1'b1, 3, e(0,0,0,0,0,0,4'b0000,0), "reset");
    // fill and backpressure, then reuse of 3 per bank
    add_fill(8, 3, "fill");
    add(1'b0, 1'b0, 1'b1, 1'b0, 3, e(0,1,0,0,0,0,4'b0000,1), "backpressure");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 7, e(0,1,1,0,0,0,4'b0000,1), "reuse_b0");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 7, e(1,1,1,1,0,0,4'b0000,1), "reuse_b1");
    add(1'b0, 1'b0, 1'b0, 1'b1, 7, e(1,0,0,0,0,0,4'b0000,0), "reuse_done");
    // zero reuse count means a single read per bank
    add_fill(8, 0, "fill_z");
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, e(0,1,1,0,0,0,4'b0000,1), "zero_b0");
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, e(1,1,1,1,0,0,4'b0000,1), "zero_b1");
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, e(1,0,0,0,0,0,4'b0000,0), "zero_done");
    // overlap: last chunk of bank 1 together with the release of bank 0
    add_fill(7, 1, "fill_ov");
    add(1'b0, 1'b0, 1'b1, 1'b1, 1, e(1,1,1,0,1,1,4'b1000,1), "overlap_fire");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1, e(1,1,0,1,0,0,4'b0000,1), "overlap_after");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1, e(1,1,1,1,0,0,4'b0000,1), "overlap_rd1");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1, e(1,0,0,0,0,0,4'b0000,0), "overlap_done");
    // flush after two chunks into bank 0
    add(1'b0, 1'b0, 1'b1, 1'b0, 2, e(1,0,0,0,1,0,4'b0001,0), "pre_flush0");
    add(1'b0, 1'b0, 1'b1, 1'b0, 2, e(1,0,0,0,1,0,4'b0010,1), "pre_flush1");
    add(1'b0, 1'b1, 1'b1, 1'b1, 2, e(0,0,0,0,0,0,4'b0000,1), "flush_cycle");
    add(1'b0, 1'b0, 1'b0, 1'b0, 2, e(1,0,0,0,0,0,4'b0000,0), "post_flush");
    add_fill(8, 2, "refill");
    // mid-read reset while bank 1 is being served
    add(1'b0, 1'b0, 1'b0, 1'b1, 2, e(0,1,1,0,0,0,4'b0000,1), "rd_b0a");
    add(1'b0, 1'b0, 1'b0, 1'b1, 2, e(0,1,1,0,0,0,4'b0000,1), "rd_b0b");
    add(1'b0, 1'b0, 1'b0, 1'b1, 2, e(1,1,1,1,0,0,4'b0000,1), "rd_b1a");
    add(1'b1, 1'b0, 1'b1, 1'b1, 2, e(0,0,0,0,0,0,4'b0000,0), "mid_reset");
    add(1'b0, 1'b0, 1'b0, 1'b1, 2, e(1,0,0,0,0,0,4'b0000,0), "post_reset");
    add_fill(8, 1, "fill_after_rst");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1, e(0,1,1,0,0,0,4'b0000,1), "final_b0");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1, e(1,1,1,1,0,0,4'b0000,1), "final_b1");
    add(1'b0, 1'b0, 1'b0, 1'b1, 1, e(1,0,0,0,0,0,4'b0000,0), "final_idle");

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].valid;
      w_ready = vecs[i].wready; reuse = vecs[i].reuse;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      got = {in_ready, w_valid, rd_en, rd_addr, wr_en, wr_addr, wsel, busy};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL row %0d %s: scoreboard empty, got %b", i, vecs[i].tag, got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL row %0d %s: got %b expected %b (ir wv re ra we wa sel busy)",
                   i, vecs[i].tag, got, want);
        end
      end
      @(posedge clk);
      #1;
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
